// File: rtl/board_checker_if.sv
// Handshake and board bus between the board update stage and the solution checker.
// The slave modport is the checker's view; the master modport is the driver's view.
interface board_checker_if #(
    parameter int BOX    = 3,
    parameter int CELL_W = 4
);
    localparam int N = BOX * BOX;

    logic                               i_start;
    logic [N-1:0][N-1:0][CELL_W-1:0]    i_display_grid;
    logic                               o_busy;
    logic                               o_done;
    logic                               o_solved;
    logic                               o_conflict;
    logic [4:0]                         o_conflict_group;
    logic [6:0]                         o_empty_count;

    modport slave (
        input  i_start, i_display_grid,
        output o_busy, o_done, o_solved, o_conflict, o_conflict_group, o_empty_count
    );

    modport master (
        output i_start, i_display_grid,
        input  o_busy, o_done, o_solved, o_conflict, o_conflict_group, o_empty_count
    );
endinterface

// File: rtl/board_checker.sv
// Sequential Sudoku checker: snapshots the board on start, then walks rows, columns
// and boxes one cell per clock, reporting solved/conflict/first bad group/empty count.
module board_checker #(
    parameter int BOX    = 3,
    parameter int CELL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    board_checker_if.slave    bus
);
    localparam int N  = BOX * BOX;
    localparam int NG = 3 * N;

    // state  | meaning
    // IDLE   | waiting for start, results held
    // SCAN   | walking snapshot, one cell per clock
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    localparam logic [4:0] GRP_NONE = 5'd31;

    logic [0:0]                         r_state;
    logic [N-1:0][N-1:0][CELL_W-1:0]    r_snap;
    logic [4:0]                         r_group;
    logic [3:0]                         r_cell;
    logic [N-1:0]                       r_seen;
    logic [6:0]                         r_empty;
    logic                               r_conf;
    logic [4:0]                         r_wgroup;

    logic                               r_busy;
    logic                               r_done;
    logic                               r_solved;
    logic                               r_conflict;
    logic [4:0]                         r_conflict_group;
    logic [6:0]                         r_empty_count;

    logic [3:0]                         w_row;
    logic [3:0]                         w_col;
    logic [CELL_W-1:0]                  w_val;
    logic                               w_dup;
    logic                               w_illegal;
    logic                               w_hit;
    logic [N-1:0]                       w_seen_nxt;
    logic                               w_empty_inc;
    logic [6:0]                         w_empty_nxt;
    logic                               w_conf_nxt;
    logic [4:0]                         w_wgroup_nxt;
    logic                               w_last;
    int                                 w_b;

    // Map (group, index) to a board coordinate: rows, then columns, then boxes.
    always_comb begin
        w_row = '0;
        w_col = '0;
        w_b   = 0;
        if (r_group < 5'd9) begin
            w_row = r_group[3:0];
            w_col = r_cell;
        end else if (r_group < 5'd18) begin
            w_row = r_cell;
            w_col = 4'(int'(r_group) - 9);
        end else begin
            w_b   = int'(r_group) - 18;
            w_row = 4'(BOX * (w_b / BOX) + int'(r_cell) / BOX);
            w_col = 4'(BOX * (w_b % BOX) + int'(r_cell) % BOX);
        end
    end

    assign w_val = r_snap[w_row][w_col];

    always_comb begin
        w_dup      = 1'b0;
        w_seen_nxt = r_seen;
        for (int i = 0; i < N; i++) begin
            if (int'(w_val) == i + 1) begin
                w_dup         = r_seen[i];
                w_seen_nxt[i] = 1'b1;
            end
        end
    end

    assign w_illegal    = int'(w_val) > N;
    assign w_hit        = w_dup | w_illegal;
    // Empties are counted on the row pass only so each cell is counted once.
    assign w_empty_inc  = (w_val == '0) && (r_group < 5'd9);
    assign w_empty_nxt  = r_empty + {6'b0, w_empty_inc};
    assign w_conf_nxt   = r_conf | w_hit;
    assign w_wgroup_nxt = (!r_conf && w_hit) ? r_group : r_wgroup;
    assign w_last       = (r_group == 5'(NG - 1)) && (r_cell == 4'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_snap           <= '0;
            r_group          <= '0;
            r_cell           <= '0;
            r_seen           <= '0;
            r_empty          <= '0;
            r_conf           <= 1'b0;
            r_wgroup         <= GRP_NONE;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_solved         <= 1'b0;
            r_conflict       <= 1'b0;
            r_conflict_group <= GRP_NONE;
            r_empty_count    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_snap   <= bus.i_display_grid;
                        r_group  <= '0;
                        r_cell   <= '0;
                        r_seen   <= '0;
                        r_empty  <= '0;
                        r_conf   <= 1'b0;
                        r_wgroup <= GRP_NONE;
                        r_busy   <= 1'b1;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_empty  <= w_empty_nxt;
                    r_conf   <= w_conf_nxt;
                    r_wgroup <= w_wgroup_nxt;
                    if (r_cell == 4'(N - 1)) begin
                        r_seen  <= '0;
                        r_cell  <= '0;
                        r_group <= r_group + 5'd1;
                    end else begin
                        r_seen  <= w_seen_nxt;
                        r_cell  <= r_cell + 4'd1;
                    end
                    if (w_last) begin
                        r_state          <= S_IDLE;
                        r_busy           <= 1'b0;
                        r_done           <= 1'b1;
                        r_solved         <= !w_conf_nxt && (w_empty_nxt == '0);
                        r_conflict       <= w_conf_nxt;
                        r_conflict_group <= w_wgroup_nxt;
                        r_empty_count    <= w_empty_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy           = r_busy;
    assign bus.o_done           = r_done;
    assign bus.o_solved         = r_solved;
    assign bus.o_conflict       = r_conflict;
    assign bus.o_conflict_group = r_conflict_group;
    assign bus.o_empty_count    = r_empty_count;
endmodule

// File: tb/tb_board_checker.sv
// Scoreboard bench for board_checker: a driver pushes expected results computed from
// Sudoku rules, and a monitor pops and compares on every done pulse.
module tb_board_checker;
    typedef logic [8:0][8:0][3:0] grid_t;

    typedef struct {
        logic solved;
        logic conflict;
        int   group;
        int   empty;
        int   start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];
    exp_t last_exp;

    board_checker_if bus ();

    board_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a group is bad if any digit appears twice or any value exceeds 9;
    // the reported group is the lowest-numbered bad group.
    function automatic exp_t model(input grid_t g);
        exp_t e;
        int   cnt[10];
        int   r, c, b, v;
        logic bad;
        e.group = 31;
        e.empty = 0;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++)
                if (g[i][j] == 4'd0) e.empty++;
        for (int grp = 0; grp < 27; grp++) begin
            for (int d = 0; d < 10; d++) cnt[d] = 0;
            bad = 1'b0;
            for (int k = 0; k < 9; k++) begin
                if (grp < 9)       begin r = grp; c = k; end
                else if (grp < 18) begin r = k; c = grp - 9; end
                else begin
                    b = grp - 18;
                    r = 3 * (b / 3) + k / 3;
                    c = 3 * (b % 3) + k % 3;
                end
                v = int'(g[r][c]);
                if (v > 9) bad = 1'b1;
                else if (v != 0) begin
                    cnt[v]++;
                    if (cnt[v] > 1) bad = 1'b1;
                end
            end
            if (bad && e.group == 31) e.group = grp;
        end
        e.conflict  = (e.group != 31);
        e.solved    = !e.conflict && (e.empty == 0);
        e.start_cyc = 0;
        return e;
    endfunction

    function automatic grid_t solved_grid();
        grid_t g;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                g[r][c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
        return g;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.o_done) begin
            check("done_width", int'(prev_done), 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency",        cyc - e.start_cyc, 243);
                check("busy_at_done",   int'(bus.o_busy), 0);
                check("solved",         int'(bus.o_solved), int'(e.solved));
                check("conflict",       int'(bus.o_conflict), int'(e.conflict));
                check("conflict_group", int'(bus.o_conflict_group), e.group);
                check("empty_count",    int'(bus.o_empty_count), e.empty);
                last_exp = e;
            end
        end
        prev_done = bus.o_done & !rst;
    end

    task automatic reset_expect();
        last_exp.solved   = 1'b0;
        last_exp.conflict = 1'b0;
        last_exp.group    = 31;
        last_exp.empty    = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     int'(bus.o_busy), 0);
        check({tag, "_done"},     int'(bus.o_done), 0);
        check({tag, "_solved"},   int'(bus.o_solved), 0);
        check({tag, "_conflict"}, int'(bus.o_conflict), 0);
        check({tag, "_group"},    int'(bus.o_conflict_group), 31);
        check({tag, "_empty"},    int'(bus.o_empty_count), 0);
    endtask

    // Called at a negedge; the start edge is the following posedge.
    task automatic start_run(input grid_t g);
        exp_t e;
        bus.i_display_grid = g;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        e = model(g);
        e.start_cyc = cyc;
        sb.push_back(e);
        check("busy_after_start", int'(bus.o_busy), 1);
        check("hold_group",       int'(bus.o_conflict_group), last_exp.group);
        check("hold_empty",       int'(bus.o_empty_count), last_exp.empty);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!bus.o_busy) ok = 1'b1;
        end
        if (!ok) check("timeout_idle", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_done();
        logic ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (bus.o_done) ok = 1'b1;
        end
        if (!ok) check("timeout_done", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        reset_expect();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");
    endtask

    initial begin
        grid_t base, g;
        bus.i_start = 1'b0;
        bus.i_display_grid = '0;
        reset_expect();
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        rst = 1'b0;
        @(negedge clk);
        base = solved_grid();

        // Reset mid-run
        start_run(base);
        repeat (30) @(negedge clk);
        do_reset();

        start_run(base);
        wait_idle();

        g = base; g[0][0] = 4'd0; g[4][4] = 4'd0; g[8][2] = 4'd0;
        start_run(g);
        wait_idle();

        g = base; g[0][0] = g[0][1];
        start_run(g);
        wait_idle();

        g = base; g[8][8] = 4'd12;
        start_run(g);
        wait_idle();

        start_run('0);
        wait_idle();

        // Back-to-back: start issued in the done cycle must be accepted
        g = base; g[3][5] = 4'd0;
        start_run(g);
        wait_done();
        start_run(base);
        wait_idle();

        // Start while busy is ignored
        start_run(base);
        repeat (20) @(negedge clk);
        bus.i_display_grid = '0;
        bus.i_start = 1'b1;
        repeat (5) @(negedge clk);
        bus.i_start = 1'b0;
        check("busy_ignore_start", int'(bus.o_busy), 1);
        wait_idle();

        // Board changes during the scan do not affect the result
        start_run(base);
        repeat (49) @(negedge clk);
        g = base; g[0][0] = g[0][1]; g[5][5] = 4'd15;
        bus.i_display_grid = g;
        wait_idle();

        // Reset at cycle 100, then a full fresh run
        start_run(g);
        repeat (99) @(negedge clk);
        do_reset();
        start_run(base);
        wait_idle();

        for (int t = 0; t < 20; t++) begin
            int nmod;
            g = base;
            nmod = $urandom_range(0, 4);
            for (int m = 0; m < nmod; m++) begin
                int r, c;
                r = $urandom_range(0, 8);
                c = $urandom_range(0, 8);
                g[r][c] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 9))
                                                      : 4'($urandom_range(0, 15));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_run(g);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
